// File: rtl/id_stage.sv
// Instruction decode stage: control decode, 32x32 register file with WB bypass,
// load-use and branch hazard stalls, early BEQ resolution, and the ID/EX pipeline register.
module id_stage (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_if_id_instruction,
  input  logic [7:0]  i_if_id_pc,
  input  logic        i_wb_reg_write,
  input  logic [4:0]  i_wb_write_reg,
  input  logic [31:0] i_wb_write_data,
  input  logic        i_ex_mem_reg_write,
  input  logic [4:0]  i_ex_mem_rd,
  output logic        o_stall,
  output logic        o_branch_taken,
  output logic [7:0]  o_branch_target,
  output logic        o_id_ex_reg_write,
  output logic        o_id_ex_mem_read,
  output logic        o_id_ex_mem_write,
  output logic        o_id_ex_mem_to_reg,
  output logic        o_id_ex_alu_src,
  output logic        o_id_ex_reg_dst,
  output logic [2:0]  o_id_ex_alu_op,
  output logic [31:0] o_id_ex_read_data1,
  output logic [31:0] o_id_ex_read_data2,
  output logic [31:0] o_id_ex_imm,
  output logic [4:0]  o_id_ex_rs,
  output logic [4:0]  o_id_ex_rt,
  output logic [4:0]  o_id_ex_rd,
  output logic [7:0]  o_id_ex_pc
);

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [15:0] w_imm16;
  logic [31:0] w_imm;

  assign w_op    = i_if_id_instruction[31:26];
  assign w_rs    = i_if_id_instruction[25:21];
  assign w_rt    = i_if_id_instruction[20:16];
  assign w_rd    = i_if_id_instruction[15:11];
  assign w_funct = i_if_id_instruction[5:0];
  assign w_imm16 = i_if_id_instruction[15:0];
  assign w_imm   = {{16{w_imm16[15]}}, w_imm16};

  // Decoded controls
  logic       w_reg_write, w_mem_read, w_mem_write, w_mem_to_reg, w_alu_src, w_reg_dst;
  logic [2:0] w_alu_op;
  logic       w_is_r, w_is_lw, w_is_sw, w_is_addi, w_is_beq;

  always_comb begin
    w_reg_write  = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_src    = 1'b0;
    w_reg_dst    = 1'b0;
    w_alu_op     = 3'b000;
    w_is_r       = 1'b0;
    w_is_lw      = 1'b0;
    w_is_sw      = 1'b0;
    w_is_addi    = 1'b0;
    w_is_beq     = 1'b0;
    case (w_op)
      6'b000000: begin
        w_is_r = 1'b1;
        case (w_funct)
          6'b100000: w_alu_op = 3'b000;
          6'b100010: w_alu_op = 3'b001;
          6'b100100: w_alu_op = 3'b010;
          6'b100101: w_alu_op = 3'b011;
          6'b101010: w_alu_op = 3'b100;
          default:   w_is_r   = 1'b0;
        endcase
        w_reg_write = w_is_r;
        w_reg_dst   = w_is_r;
      end
      6'b100011: begin
        w_is_lw      = 1'b1;
        w_reg_write  = 1'b1;
        w_mem_read   = 1'b1;
        w_mem_to_reg = 1'b1;
        w_alu_src    = 1'b1;
      end
      6'b101011: begin
        w_is_sw     = 1'b1;
        w_mem_write = 1'b1;
        w_alu_src   = 1'b1;
      end
      6'b001000: begin
        w_is_addi   = 1'b1;
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
      end
      6'b000100: begin
        w_is_beq = 1'b1;
        w_alu_op = 3'b001;
      end
      default: ;
    endcase
  end

  // Register file with same-cycle WB bypass
  logic [31:0] r_regs [32];
  logic [31:0] w_rs_val, w_rt_val;

  assign w_rs_val = (w_rs == 5'd0) ? 32'd0 :
                    (i_wb_reg_write && i_wb_write_reg == w_rs) ? i_wb_write_data : r_regs[w_rs];
  assign w_rt_val = (w_rt == 5'd0) ? 32'd0 :
                    (i_wb_reg_write && i_wb_write_reg == w_rt) ? i_wb_write_data : r_regs[w_rt];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
    end else if (i_wb_reg_write && i_wb_write_reg != 5'd0) begin
      r_regs[i_wb_write_reg] <= i_wb_write_data;
    end
  end

  // Hazard detection
  logic       r_reg_write, r_mem_read, r_mem_write, r_mem_to_reg, r_alu_src, r_reg_dst;
  logic [2:0] r_alu_op;
  logic [31:0] r_read_data1, r_read_data2, r_imm;
  logic [4:0] r_rs, r_rt, r_rd;
  logic [7:0] r_pc;

  logic       w_uses_rs, w_uses_rt, w_load_use, w_branch_stall, w_stall, w_taken;
  logic [4:0] w_ex_dest;

  assign w_uses_rs  = w_is_r | w_is_lw | w_is_sw | w_is_addi | w_is_beq;
  assign w_uses_rt  = w_is_r | w_is_sw | w_is_beq;
  assign w_load_use = r_mem_read && (r_rt != 5'd0) &&
                      ((w_uses_rs && r_rt == w_rs) || (w_uses_rt && r_rt == w_rt));

  assign w_ex_dest      = r_reg_dst ? r_rd : r_rt;
  assign w_branch_stall = w_is_beq && (
      (r_reg_write && w_ex_dest != 5'd0 && (w_ex_dest == w_rs || w_ex_dest == w_rt)) ||
      (i_ex_mem_reg_write && i_ex_mem_rd != 5'd0 &&
       (i_ex_mem_rd == w_rs || i_ex_mem_rd == w_rt)));

  assign w_stall = w_load_use | w_branch_stall;
  assign w_taken = w_is_beq && !w_stall && (w_rs_val == w_rt_val);

  assign o_stall         = w_stall;
  assign o_branch_taken  = w_taken;
  assign o_branch_target = w_taken ? (i_if_id_pc + 8'd1 + w_imm16[7:0]) : 8'd0;

  // ID/EX register; stalls and taken branches inject a bubble
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_alu_src    <= 1'b0;
      r_reg_dst    <= 1'b0;
      r_alu_op     <= 3'b000;
      r_read_data1 <= 32'd0;
      r_read_data2 <= 32'd0;
      r_imm        <= 32'd0;
      r_rs         <= 5'd0;
      r_rt         <= 5'd0;
      r_rd         <= 5'd0;
      r_pc         <= 8'd0;
    end else begin
      if (w_stall || w_taken) begin
        r_reg_write  <= 1'b0;
        r_mem_read   <= 1'b0;
        r_mem_write  <= 1'b0;
        r_mem_to_reg <= 1'b0;
        r_alu_src    <= 1'b0;
        r_reg_dst    <= 1'b0;
        r_alu_op     <= 3'b000;
      end else begin
        r_reg_write  <= w_reg_write;
        r_mem_read   <= w_mem_read;
        r_mem_write  <= w_mem_write;
        r_mem_to_reg <= w_mem_to_reg;
        r_alu_src    <= w_alu_src;
        r_reg_dst    <= w_reg_dst;
        r_alu_op     <= w_alu_op;
      end
      r_read_data1 <= w_rs_val;
      r_read_data2 <= w_rt_val;
      r_imm        <= w_imm;
      r_rs         <= w_rs;
      r_rt         <= w_rt;
      r_rd         <= w_rd;
      r_pc         <= i_if_id_pc;
    end
  end

  assign o_id_ex_reg_write  = r_reg_write;
  assign o_id_ex_mem_read   = r_mem_read;
  assign o_id_ex_mem_write  = r_mem_write;
  assign o_id_ex_mem_to_reg = r_mem_to_reg;
  assign o_id_ex_alu_src    = r_alu_src;
  assign o_id_ex_reg_dst    = r_reg_dst;
  assign o_id_ex_alu_op     = r_alu_op;
  assign o_id_ex_read_data1 = r_read_data1;
  assign o_id_ex_read_data2 = r_read_data2;
  assign o_id_ex_imm        = r_imm;
  assign o_id_ex_rs         = r_rs;
  assign o_id_ex_rt         = r_rt;
  assign o_id_ex_rd         = r_rd;
  assign o_id_ex_pc         = r_pc;

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
- REQ-001 Parameters: none; PC width fixed at 8 bits, data width fixed at 32 bits.
- REQ-002 clk  in  1  single clock; all state updates on rising edge.
- REQ-003 rst  in  1  synchronous, active-high reset.
- REQ-004 IF_ID_Instruction  in  32  instruction held in IF/ID.
- REQ-005 IF_ID_PC  in  8  word address of that instruction.
- REQ-006 WB_RegWrite / WB_WriteReg / WB_WriteData  in  1/5/32  register-file write port from WB.
- REQ-007 EX_MEM_RegWrite / EX_MEM_Rd  in  1/5  pending write in MEM, for branch hazard check.
- REQ-008 Stall  out  1  combinational; IF holds PC and IF/ID when high.
- REQ-009 BranchTaken / BranchTarget  out  1/8  combinational branch resolution to IF_STAGE.
- REQ-010 ID_EX_RegWrite, _MemRead, _MemWrite, _MemToReg, _ALUSrc, _RegDst  out  1 each  registered controls.
- REQ-011 ID_EX_ALUOp  out  3  registered ALU op: 000 add, 001 sub, 010 and, 011 or, 100 slt.
- REQ-012 ID_EX_ReadData1 / ID_EX_ReadData2 / ID_EX_Imm  out  32 each  registered operands, sign-extended imm.
- REQ-013 ID_EX_Rs / ID_EX_Rt / ID_EX_Rd / ID_EX_PC  out  5/5/5/8  registered fields.

Function
- REQ-014 Fields: op[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0].
- REQ-015 Decode: op 000000 R-type (funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt: RegWrite, RegDst); 100011 LW (RegWrite, MemRead, MemToReg, ALUSrc, add); 101011 SW (MemWrite, ALUSrc, add); 001000 ADDI (RegWrite, ALUSrc, add); 000100 BEQ (no controls, sub).
- REQ-016 Any other op/funct, and all-zero word, decode as bubble: every control 0, ALUOp 000.
- REQ-017 Register file 32x32; r0 reads 0 always, writes to r0 ignored.
- REQ-018 Write on clk when WB_RegWrite=1; same-cycle read of WB_WriteReg (nonzero) returns WB_WriteData (bypass).
- REQ-019 Load-use stall: ID_EX_MemRead=1, ID_EX_Rt!=0, and ID_EX_Rt equals rs, or rt for R-type/SW/BEQ.
- REQ-020 Branch stall: BEQ and a source (nonzero) matches ID_EX dest (RegDst?Rd:Rt) with ID_EX_RegWrite=1, or EX_MEM_Rd with EX_MEM_RegWrite=1.
- REQ-021 While Stall=1, ID/EX loads a bubble (controls 0); data fields don't-care; BranchTaken=0.
- REQ-022 BranchTaken=1 iff BEQ, Stall=0, and bypassed rs value equals rt value.
- REQ-023 BranchTarget = IF_ID_PC + 1 + imm[7:0], modulo 256; valid only while BranchTaken=1, else 0.
- REQ-024 Taken BEQ loads a bubble into ID/EX; IF_STAGE squashes the wrong-path fetch.
- REQ-025 Otherwise, ID/EX registers capture decoded values each clk, latency exactly 1 cycle.
- REQ-026 Register-file write and ID/EX update in same cycle are independent; stall never blocks WB writes.

Reset
- REQ-027 rst=1 at clk edge clears all ID/EX outputs to 0 (bubble) and all 32 registers to 0.
- REQ-028 Combinational outputs during reset follow REQ-019..REQ-023 from cleared state (Stall=0, BranchTaken=0).
- REQ-029 rst mid-stall or mid-branch: state cleared next edge; no pending stall or branch survives.

Verification
- REQ-030 rst 1 cycle, then IF_ID_Instruction=0 -> all ID_EX outputs 0, Stall=0, BranchTaken=0.
- REQ-031 WB writes r1=5 and r2=7; ADD r3,r1,r2 (0x00221820) -> next cycle ReadData1=5, ReadData2=7, RegWrite=1, RegDst=1, ALUOp=000.
- REQ-032 LW r4,8(r1) (0x8C240008), then ADD r5,r4,r1 -> Stall=1 one cycle, bubble in ID/EX, ADD issues next cycle.
- REQ-033 WB_RegWrite r6=9 same cycle ID reads r6 -> ReadData1=9 registered (bypass).
- REQ-034 r1=r2=5, BEQ r1,r2,+3 at IF_ID_PC=10 -> BranchTaken=1, BranchTarget=14, ID/EX bubble; r2=6 -> BranchTaken=0.
- REQ-035 WB write to r0 value 0xFFFFFFFF, then read r0 -> ReadData1=0; IF_ID_PC=255 BEQ imm=0 taken -> BranchTarget=0 (wrap).
